// File: rtl/ysyx_25020032_ifu_pf_if.sv
// Fetch-unit bus bundle: AXI4 read channel, decode handshake, redirect.
// master = fetch unit, slave = memory/decode environment.
interface ysyx_25020032_ifu_pf_if;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic [3:0]  rid;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_fault;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        finish;

    modport master (
        output arvalid, araddr, arid, arlen, arsize, arburst,
        output rready,
        output out_valid, out_pc, out_instr, out_fault, finish,
        input  arready, rvalid, rdata, rresp, rlast, rid,
        input  out_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  arvalid, araddr, arid, arlen, arsize, arburst,
        input  rready,
        input  out_valid, out_pc, out_instr, out_fault, finish,
        output arready, rvalid, rdata, rresp, rlast, rid,
        output out_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/ysyx_25020032_ifu_pf.sv
// Prefetching instruction fetch unit: single-beat AXI4 reads into a
// small instruction buffer, with redirect flush and stale-beat dropping.
module ysyx_25020032_ifu_pf #(
    parameter logic [31:0] RESET_PC = 32'h2000_0000,
    parameter int          DEPTH    = 4
) (
    input logic clk,
    input logic rst,
    ysyx_25020032_ifu_pf_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    typedef logic [CW-1:0] cnt_t;

    logic [31:0] fpc, fpc_n;
    logic [31:0] resp_pc, resp_pc_n;
    logic [31:0] pend_addr, pend_addr_n;
    logic        pend_drop, pend_drop_n;
    logic        arv, arv_n;
    cnt_t        inflight, inflight_n;
    cnt_t        drop_cnt, drop_cnt_n;
    cnt_t        count, count_n;
    logic [AW-1:0] wptr, rptr;
    logic [CW:0] sum_n;

    logic [31:0] q_pc    [DEPTH];
    logic [31:0] q_instr [DEPTH];
    logic        q_fault [DEPTH];

    logic ar_hs, r_hs, drop, push, out_hs, pop, redir, ar_stall;
    logic unused_r;

    assign redir    = bus.redirect_valid;
    assign ar_hs    = arv && bus.arready;
    assign ar_stall = arv && !bus.arready;
    assign r_hs     = bus.rvalid && (inflight != '0);
    assign drop     = r_hs && (drop_cnt != '0);
    assign push     = r_hs && !drop && !redir;
    assign out_hs   = (count != '0) && bus.out_ready;
    assign pop      = out_hs && !redir;

    always_comb begin
        inflight_n  = inflight + cnt_t'(ar_hs) - cnt_t'(r_hs);
        count_n     = count + cnt_t'(push) - cnt_t'(pop);
        drop_cnt_n  = drop_cnt - cnt_t'(drop)
                    + cnt_t'(ar_hs && pend_drop);
        fpc_n       = fpc;
        resp_pc_n   = resp_pc;
        pend_drop_n = pend_drop;
        pend_addr_n = pend_addr;
        if (ar_hs && !pend_drop)
            fpc_n = fpc + 32'd4;
        if (ar_hs)
            pend_drop_n = 1'b0;
        if (push)
            resp_pc_n = resp_pc + 32'd4;
        if (redir) begin
            count_n    = '0;
            drop_cnt_n = inflight_n;
            fpc_n      = bus.redirect_pc;
            resp_pc_n  = bus.redirect_pc;
            // A stalled request keeps its old address; drop it once accepted.
            if (ar_stall) begin
                pend_drop_n = 1'b1;
                if (!pend_drop)
                    pend_addr_n = fpc;
            end
        end
        sum_n = {1'b0, inflight_n} + {1'b0, count_n};
        arv_n = ar_stall || (sum_n < (CW+1)'(DEPTH));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fpc       <= RESET_PC;
            resp_pc   <= RESET_PC;
            pend_addr <= RESET_PC;
            pend_drop <= 1'b0;
            arv       <= 1'b0;
            inflight  <= '0;
            drop_cnt  <= '0;
            count     <= '0;
            wptr      <= '0;
            rptr      <= '0;
        end else begin
            fpc       <= fpc_n;
            resp_pc   <= resp_pc_n;
            pend_addr <= pend_addr_n;
            pend_drop <= pend_drop_n;
            arv       <= arv_n;
            inflight  <= inflight_n;
            drop_cnt  <= drop_cnt_n;
            count     <= count_n;
            wptr      <= redir ? '0 : wptr + AW'(push);
            rptr      <= redir ? '0 : rptr + AW'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_pc[i]    <= '0;
                q_instr[i] <= '0;
                q_fault[i] <= 1'b0;
            end
        end else if (push) begin
            q_pc[wptr]    <= resp_pc;
            q_instr[wptr] <= bus.rdata;
            q_fault[wptr] <= (bus.rresp != 2'b00);
        end
    end

    assign bus.arvalid   = arv;
    assign bus.araddr    = pend_drop ? pend_addr : fpc;
    assign bus.arid      = 4'd0;
    assign bus.arlen     = 8'd0;
    assign bus.arsize    = 3'b010;
    assign bus.arburst   = 2'b01;
    assign bus.rready    = 1'b1;
    assign bus.out_valid = (count != '0);
    assign bus.out_pc    = q_pc[rptr];
    assign bus.out_instr = q_instr[rptr];
    assign bus.out_fault = q_fault[rptr];
    assign bus.finish    = out_hs && (q_instr[rptr] == EBREAK);

    assign unused_r = ^{bus.rlast, bus.rid};
endmodule

// File: tb/tb_ysyx_25020032_ifu_pf.sv
// Bench for the prefetching fetch unit: AXI memory model plus an
// expected-instruction scoreboard checked on each decode handshake.
module tb_ysyx_25020032_ifu_pf;
    localparam logic [31:0] RPC = 32'h2000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ysyx_25020032_ifu_pf_if bus();

    ysyx_25020032_ifu_pf #(.RESET_PC(RPC), .DEPTH(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    ent_t        sbq[$];
    logic [31:0] rq[$];
    int total = 0;
    int bad = 0;
    int ar_cnt, out_cnt, fin_cnt, ar_budget, n0;
    bit mem_go, ebreak_en, redir_pend, prev_pend;
    logic [31:0] fault_addr, ebreak_addr, ar_exp, ar_redir, prev_addr;

    function automatic logic [31:0] mem_word(logic [31:0] a);
        if (ebreak_en && a == ebreak_addr)
            return 32'h0010_0073;
        return {~a[15:0], a[15:0]};
    endfunction

    function automatic ent_t mk(logic [31:0] pc);
        ent_t e;
        e.pc    = pc;
        e.instr = mem_word(pc);
        e.fault = (pc == fault_addr);
        return e;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_run(logic [31:0] base, int n);
        for (int i = 0; i < n; i++)
            sbq.push_back(mk(base + 32'(4 * i)));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sbq.delete();
        ar_cnt = 0;
        out_cnt = 0;
        fin_cnt = 0;
        ar_exp = RPC;
        redir_pend = 1'b0;
        step(2);
        rst = 1'b0;
        push_run(RPC, 100);
        chk("arvalid_after_rst", 32'(bus.arvalid), 0);
        step(1);
        chk("first_arvalid", 32'(bus.arvalid), 1);
        chk("first_araddr", bus.araddr, RPC);
    endtask

    task automatic redirect_to(logic [31:0] pc, bit pend);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = pc;
        step(1);
        bus.redirect_valid = 1'b0;
        sbq.delete();
        push_run(pc, 100);
        if (pend) begin
            ar_redir = pc;
            redir_pend = 1'b1;
        end else begin
            ar_exp = pc;
        end
        chk("flush_empty", 32'(bus.out_valid), 0);
    endtask

    initial begin : mem_model
        logic [31:0] a;
        ent_t e;
        bus.arready = 1'b0;
        bus.rvalid = 1'b0;
        bus.rdata = '0;
        bus.rresp = 2'b00;
        bus.rlast = 1'b1;
        bus.rid = 4'd0;
        forever begin
            @(negedge clk);
            if (rst) begin
                rq.delete();
                bus.rvalid = 1'b0;
                bus.arready = 1'b0;
                prev_pend = 1'b0;
            end else begin
                if (prev_pend) begin
                    chk("ar_hold_valid", 32'(bus.arvalid), 1);
                    chk("ar_hold_addr", bus.araddr, prev_addr);
                end
                if (mem_go && rq.size() > 0) begin
                    a = rq.pop_front();
                    bus.rvalid = 1'b1;
                    bus.rdata = mem_word(a);
                    bus.rresp = (a == fault_addr) ? 2'b10 : 2'b00;
                end else begin
                    bus.rvalid = 1'b0;
                end
                bus.arready = (ar_budget > 0);
                if (bus.arvalid && bus.arready) begin
                    ar_cnt++;
                    ar_budget--;
                    rq.push_back(bus.araddr);
                    chk("araddr", bus.araddr, ar_exp);
                    chk("ar_const",
                        {15'd0, bus.arid, bus.arlen, bus.arsize, bus.arburst},
                        {15'd0, 4'd0, 8'd0, 3'b010, 2'b01});
                    if (redir_pend) begin
                        ar_exp = ar_redir;
                        redir_pend = 1'b0;
                    end else begin
                        ar_exp = ar_exp + 32'd4;
                    end
                end
                prev_pend = bus.arvalid && !bus.arready;
                prev_addr = bus.araddr;
                if (bus.out_valid && bus.out_ready) begin
                    out_cnt++;
                    if (sbq.size() == 0) begin
                        chk("sb_empty", 32'(sbq.size()), 1);
                    end else begin
                        e = sbq.pop_front();
                        chk("out_pc", bus.out_pc, e.pc);
                        chk("out_instr", bus.out_instr, e.instr);
                        chk("out_fault", 32'(bus.out_fault), 32'(e.fault));
                    end
                end
                if (bus.finish)
                    fin_cnt++;
            end
        end
    end

    initial begin : stim
        rst = 1'b1;
        bus.out_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        mem_go = 1'b1;
        ebreak_en = 1'b0;
        ebreak_addr = RPC + 32'h10;
        fault_addr = '0;
        ar_budget = 1000000;
        ar_exp = RPC;
        redir_pend = 1'b0;
        step(2);
        chk("rst_arvalid", 32'(bus.arvalid), 0);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_rready", 32'(bus.rready), 1);

        // streaming, one instruction per cycle
        bus.out_ready = 1'b1;
        do_reset();
        step(5);
        n0 = out_cnt;
        step(10);
        chk("steady_rate", 32'(out_cnt - n0), 10);

        // decode stalled: buffer plus in-flight reads capped at 4
        bus.out_ready = 1'b0;
        do_reset();
        step(12);
        chk("stall_ar_cnt", 32'(ar_cnt), 4);
        chk("stall_arvalid", 32'(bus.arvalid), 0);
        chk("stall_out_valid", 32'(bus.out_valid), 1);
        bus.out_ready = 1'b1;
        step(20);
        chk("resume_fetch", 32'(ar_cnt > 12), 1);
        chk("resume_out", 32'(out_cnt > 12), 1);

        // three reads in flight, redirect drops them
        mem_go = 1'b0;
        ar_budget = 3;
        do_reset();
        step(8);
        chk("inflight_ar", 32'(ar_cnt), 3);
        chk("inflight_out", 32'(out_cnt), 0);
        redirect_to(RPC + 32'h100, 1'b1);
        ar_budget = 1000000;
        mem_go = 1'b1;
        step(15);
        chk("redir_progress", 32'(out_cnt > 5), 1);

        // redirect while a request is stalled on arready
        ar_budget = 2;
        do_reset();
        step(6);
        chk("stall_req_valid", 32'(bus.arvalid), 1);
        chk("stall_req_addr", bus.araddr, RPC + 32'h8);
        redirect_to(RPC + 32'h200, 1'b1);
        step(3);
        chk("held_addr", bus.araddr, RPC + 32'h8);
        n0 = out_cnt;
        ar_budget = 1000000;
        step(15);
        chk("redir2_progress", 32'(out_cnt - n0 > 5), 1);

        // back-to-back redirects: only the last target is fetched
        mem_go = 1'b0;
        ar_budget = 3;
        do_reset();
        step(8);
        redirect_to(RPC + 32'h300, 1'b1);
        redirect_to(RPC + 32'h400, 1'b1);
        ar_budget = 1000000;
        mem_go = 1'b1;
        step(20);
        chk("b2b_progress", 32'(out_cnt > 5), 1);

        // bus error on the second word, ebreak at 0x10
        fault_addr = RPC + 32'h4;
        ebreak_en = 1'b1;
        do_reset();
        step(30);
        chk("fault_continue", 32'(out_cnt > 20), 1);
        chk("finish_once", 32'(fin_cnt), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ysyx_25020032_ifu_pf.md
YSYX_25020032_IFU_PF -- requirements
Module: ysyx_25020032_ifu_pf

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h2000_0000, meaning first fetch address.
REQ-002 SHALL have parameter DEPTH, default 4, meaning instruction buffer entries and max in-flight reads (power of 2, >=2).
REQ-003 SHALL have port clk  input  1  clock.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports out_valid output 1, out_ready input 1: instruction handshake to decode.
REQ-006 SHALL have ports out_pc output 32, out_instr output 32, out_fault output 1: head-entry PC, word, and error flag.
REQ-007 SHALL have ports redirect_valid input 1, redirect_pc input 32: branch/exception redirect.
REQ-008 SHALL have AXI4 read-address ports arvalid out 1, arready in 1, araddr out 32, arid out 4, arlen out 8, arsize out 3, arburst out 2.
REQ-009 SHALL have AXI4 read-data ports rvalid in 1, rready out 1, rdata in 32, rresp in 2, rlast in 1, rid in 4.

Function
REQ-010 SHALL drive constants arid=0, arlen=0, arsize=3'b010, arburst=2'b01 (INCR).
REQ-011 SHALL hold fetch pointer fpc; araddr=fpc while arvalid; fpc+=4 (mod 2^32) on each AR handshake.
REQ-012 SHALL assert arvalid only when inflight+fifo_count < DEPTH; once asserted, arvalid and araddr SHALL stay stable until arready.
REQ-013 SHALL tie rready=1 (space reserved by REQ-012); inflight +1 on AR handshake, -1 on R handshake, both same cycle = unchanged.
REQ-014 SHALL track resp_pc: a non-dropped R beat pushes {resp_pc, rdata, rresp!=2'b00} into the FIFO and sets resp_pc+=4.
REQ-015 SHALL drive out_valid=(fifo_count!=0), out_* from head entry; pop on out_valid&&out_ready; push and pop same cycle allowed when full.
REQ-016 SHALL not stall fetch on fault; out_fault only marks the entry.
REQ-017 On redirect_valid SHALL, next cycle: FIFO empty, fpc=redirect_pc, resp_pc=redirect_pc, drop_cnt=inflight after this cycle's handshakes.
REQ-018 If redirect occurs while arvalid&&!arready, the pending request SHALL complete with old address and SHALL be added to drop_cnt on acceptance; new address issued only afterwards.
REQ-019 While drop_cnt>0 each R beat SHALL be discarded and drop_cnt-=1; no push.
REQ-020 Redirect SHALL win over same-cycle push and pop; a same-cycle out handshake still counts as consumed by decode.
REQ-021 Back-to-back redirects SHALL accumulate drops; only the last redirect_pc is fetched.
REQ-022 SHALL call set_finish() when an entry with out_instr==32'h00100073 completes the out handshake.
REQ-023 inflight and drop_cnt SHALL be clog2(DEPTH)+1 bits and never over/underflow.

Reset
REQ-024 Asynchronous rst SHALL clear arvalid, out_valid, inflight, drop_cnt, FIFO, set fpc=resp_pc=RESET_PC; rready=1.
REQ-025 First arvalid SHALL assert on the first clk edge after rst deasserts; rst mid-transaction abandons all in-flight reads (bench SHALL reset the memory model too).

Verification
REQ-026 Reset, arready=1, 1-cycle memory, out_ready=1 -> araddr 0x20000000,0x20000004,... ; out_pc matches, steady one instruction/cycle.
REQ-027 out_ready=0, DEPTH=4 -> exactly 4 AR handshakes then arvalid=0; out_ready=1 -> order preserved, fetch resumes.
REQ-028 3 reads in flight, redirect to 0x20000100 -> 3 R beats dropped, next out_pc=0x20000100.
REQ-029 Redirect while arvalid&&!arready at 0x20000008 -> araddr stays 0x20000008 until arready, its beat dropped, then araddr 0x20000200.
REQ-030 rresp=2'b10 on second beat -> out_fault=1 only for pc 0x20000004, fetch continues.
REQ-031 Memory returns 32'h00100073 -> set_finish called once on its out handshake.
